// File: rtl/iob_eth_rx_mii_pkg.sv
// Shared definitions for the MII receive front end.
// Holds the preamble and SFD nibble values, the default maximum frame length,
// the frame length width and the receive FSM state encoding.
package iob_eth_rx_mii_pkg;

    localparam logic [3:0] ETH_PRE_NIB   = 4'h5;
    localparam logic [3:0] ETH_SFD_NIB   = 4'hD;
    localparam int         DEF_MAX_BYTES = 1522;
    localparam int         LEN_W         = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } rx_state_t;

endpackage

// File: rtl/iob_eth_rx_mii_if.sv
// Byte stream produced by the MII receive front end.
// Signals:
//   rx_byte  assembled byte, meaningful when rx_valid
//   rx_valid one-cycle strobe per byte
//   rx_sof   high with rx_valid on the first byte of a frame
//   rx_eof   one-cycle end-of-frame strobe, never together with rx_valid
//   rx_err   frame status, meaningful with rx_eof
//   rx_len   frame byte count, meaningful with rx_eof
// Handshake: push-only stream with no ready. A byte is transferred on every
// cycle rx_valid is high and a frame ends on every cycle rx_eof is high; the
// consumer must accept both unconditionally. rx_byte, rx_len and rx_err hold
// their last value between strobes.
interface iob_eth_rx_mii_if;
    import iob_eth_rx_mii_pkg::*;

    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_sof;
    logic             rx_eof;
    logic             rx_err;
    logic [LEN_W-1:0] rx_len;

    modport master (
        output rx_byte, rx_valid, rx_sof, rx_eof, rx_err, rx_len
    );

    modport slave (
        input rx_byte, rx_valid, rx_sof, rx_eof, rx_err, rx_len
    );
endinterface

// File: rtl/iob_eth_rst_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts on the second clock
// edge after the input reset is released.
// Ports:
//   clk      clock of the destination domain
//   rst      async active-high reset in
//   rst_out  active-high reset with synchronised deassertion
module iob_eth_rst_sync (
    input  logic clk,
    input  logic rst,
    output logic rst_out
);
    logic [1:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], 1'b0};
        end
    end

    assign rst_out = sync[1];
endmodule

// File: rtl/iob_eth_rx_mii.sv
// MII receive front end. Registers the PHY pins, strips preamble and SFD,
// assembles nibbles (low nibble first) into bytes and reports frame end with
// length and error status. Keeps good/bad frame counters.
// Ports:
//   RX_CLK      PHY receive clock; all logic runs here
//   rst         async active-high reset (deassertion synchronised internally)
//   RX_DV       MII data valid
//   RX_ER       MII receive error
//   RX_DATA     MII nibble
//   rx          byte stream out (master modport)
//   frames_ok   count of frames ending without error (wraps)
//   frames_bad  count of frames ending with error (wraps)
//   state       current receive FSM state, for observation
module iob_eth_rx_mii
    import iob_eth_rx_mii_pkg::*;
#(
    parameter int MIN_PRE_NIB = 2,
    parameter int MAX_BYTES   = DEF_MAX_BYTES,
    parameter int CNT_W       = 16
) (
    input  logic               RX_CLK,
    input  logic               rst,
    input  logic               RX_DV,
    input  logic               RX_ER,
    input  logic [3:0]         RX_DATA,
    iob_eth_rx_mii_if.master   rx,
    output logic [CNT_W-1:0]   frames_ok,
    output logic [CNT_W-1:0]   frames_bad,
    output rx_state_t          state
);
    localparam logic [3:0]       MIN_PRE = 4'(MIN_PRE_NIB);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    logic rst_i;

    iob_eth_rst_sync u_rst_sync (
        .clk     (RX_CLK),
        .rst     (rst),
        .rst_out (rst_i)
    );

    // Stage 1: pin registers
    logic       in_dv;
    logic       in_er;
    logic [3:0] in_d;

    always_ff @(posedge RX_CLK or posedge rst_i) begin
        if (rst_i) begin
            in_dv <= 1'b0;
            in_er <= 1'b0;
            in_d  <= 4'h0;
        end else begin
            in_dv <= RX_DV;
            in_er <= RX_ER;
            in_d  <= RX_DATA;
        end
    end

    // Stage 2: receive FSM with registered outputs
    logic [3:0]       pre_cnt;
    logic             phase;     // 1 when the low nibble of a byte is held
    logic [3:0]       low;
    logic [LEN_W-1:0] byte_cnt;
    logic             err_s;     // sticky RX_ER seen within the current frame
    logic             end_err;

    // Error status for a frame ended by RX_DV dropping
    assign end_err = err_s | phase | (byte_cnt == '0);

    always_ff @(posedge RX_CLK or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            pre_cnt     <= 4'd0;
            phase       <= 1'b0;
            low         <= 4'h0;
            byte_cnt    <= '0;
            err_s       <= 1'b0;
            rx.rx_byte  <= 8'h00;
            rx.rx_valid <= 1'b0;
            rx.rx_sof   <= 1'b0;
            rx.rx_eof   <= 1'b0;
            rx.rx_err   <= 1'b0;
            rx.rx_len   <= '0;
            frames_ok   <= '0;
            frames_bad  <= '0;
        end else begin
            rx.rx_valid <= 1'b0;
            rx.rx_sof   <= 1'b0;
            rx.rx_eof   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_dv) begin
                        if (in_d == ETH_PRE_NIB) begin
                            state   <= ST_PRE;
                            pre_cnt <= 4'd1;
                        end else begin
                            state <= ST_DROP;
                        end
                    end
                end
                ST_PRE: begin
                    if (!in_dv) begin
                        state <= ST_IDLE;
                    end else if (in_d == ETH_PRE_NIB) begin
                        if (pre_cnt != 4'hF) begin
                            pre_cnt <= pre_cnt + 4'd1;
                        end
                    end else if (in_d == ETH_SFD_NIB && pre_cnt >= MIN_PRE) begin
                        state    <= ST_DATA;
                        phase    <= 1'b0;
                        byte_cnt <= '0;
                        err_s    <= 1'b0;
                    end else begin
                        state <= ST_DROP;
                    end
                end
                ST_DATA: begin
                    if (!in_dv) begin
                        rx.rx_eof <= 1'b1;
                        rx.rx_len <= byte_cnt;
                        rx.rx_err <= end_err;
                        if (end_err) begin
                            frames_bad <= frames_bad + CNT_W'(1);
                        end else begin
                            frames_ok <= frames_ok + CNT_W'(1);
                        end
                        state <= ST_IDLE;
                    end else if (!phase) begin
                        low   <= in_d;
                        phase <= 1'b1;
                        err_s <= err_s | in_er;
                    end else if (byte_cnt < MAX_LEN) begin
                        rx.rx_byte  <= {in_d, low};
                        rx.rx_valid <= 1'b1;
                        rx.rx_sof   <= (byte_cnt == '0);
                        byte_cnt    <= byte_cnt + LEN_W'(1);
                        phase       <= 1'b0;
                        err_s       <= err_s | in_er;
                    end else begin
                        // One byte past the limit: close the frame as bad and
                        // discard the remainder.
                        rx.rx_eof  <= 1'b1;
                        rx.rx_len  <= MAX_LEN;
                        rx.rx_err  <= 1'b1;
                        frames_bad <= frames_bad + CNT_W'(1);
                        state      <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (!in_dv) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iob_eth_rx_mii.sv
// Bench for iob_eth_rx_mii: directed frames plus randomized frames, checked by
// a scoreboard fed from a frame-level reference model.
module tb_iob_eth_rx_mii;
    import iob_eth_rx_mii_pkg::*;

    localparam int MIN_PRE = 2;
    localparam int MAXB    = 4;
    localparam int CW      = 16;
    localparam int W       = 22;

    logic           RX_CLK = 1'b0;
    logic           rst    = 1'b1;
    logic           RX_DV  = 1'b0;
    logic           RX_ER  = 1'b0;
    logic [3:0]     RX_DATA = 4'h0;
    logic [CW-1:0]  frames_ok;
    logic [CW-1:0]  frames_bad;
    rx_state_t      state;

    iob_eth_rx_mii_if rx ();

    iob_eth_rx_mii #(
        .MIN_PRE_NIB (MIN_PRE),
        .MAX_BYTES   (MAXB),
        .CNT_W       (CW)
    ) dut (
        .RX_CLK     (RX_CLK),
        .rst        (rst),
        .RX_DV      (RX_DV),
        .RX_ER      (RX_ER),
        .RX_DATA    (RX_DATA),
        .rx         (rx),
        .frames_ok  (frames_ok),
        .frames_bad (frames_bad),
        .state      (state)
    );

    // clock / reset
    always #5 RX_CLK = ~RX_CLK;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    logic [3:0]   data_nib[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           exp_ok   = 0;
    int           exp_bad  = 0;

    function automatic logic [W-1:0] pack(input bit eof, input bit sof, input bit err,
                                          input logic [10:0] len, input logic [7:0] b);
        return {eof, sof, err, len, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_item(input string name, input logic [W-1:0] act);
        logic [W-1:0] req;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: unexpected output %h, nothing expected", name, act);
        end else begin
            req = exp_q.pop_front();
            if (act !== req) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h", name, act, req);
            end
        end
    endtask

    // monitor
    always @(negedge RX_CLK) begin
        if (!rst) begin
            if (rx.rx_valid && rx.rx_eof) begin
                n_checks++;
                n_errors++;
                $display("FAIL valid_eof_overlap: got both high, required exclusive");
            end
            if (rx.rx_valid) begin
                check_item("byte", pack(1'b0, rx.rx_sof, 1'b0, 11'd0, rx.rx_byte));
            end else if (rx.rx_eof) begin
                check_item("eof", pack(1'b1, 1'b0, rx.rx_err, rx.rx_len, 8'h00));
            end
        end
    end

    // driver tasks
    task automatic drive(input bit dv, input bit er, input logic [3:0] d);
        RX_DV   = dv;
        RX_ER   = er;
        RX_DATA = d;
        @(posedge RX_CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0);
    endtask

    // Reference model: a frame is accepted if it has at least MIN_PRE preamble
    // nibbles followed by an SFD; its bytes are consecutive nibble pairs of
    // data_nib, truncated at MAXB with an error if a byte beyond MAXB completes.
    task automatic send_frame(input int pre_n, input bit sfd_ok, input int er_pos, input int gap);
        int   nnib;
        int   nbytes;
        int   nemit;
        bit   err;
        logic [10:0] len;
        nnib = data_nib.size();
        if (sfd_ok && pre_n >= MIN_PRE) begin
            nbytes = nnib / 2;
            nemit  = (nbytes > MAXB) ? MAXB : nbytes;
            for (int k = 0; k < nemit; k++) begin
                exp_q.push_back(pack(1'b0, k == 0, 1'b0, 11'd0,
                                     {data_nib[2*k+1], data_nib[2*k]}));
            end
            if (nbytes > MAXB) begin
                err = 1'b1;
                len = 11'(MAXB);
            end else begin
                len = 11'(nbytes);
                err = (er_pos >= 0 && er_pos < nnib) || (nnib % 2 == 1) || (nbytes == 0);
            end
            exp_q.push_back(pack(1'b1, 1'b0, err, len, 8'h00));
            if (err) exp_bad++;
            else     exp_ok++;
        end
        for (int i = 0; i < pre_n; i++) drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b0, sfd_ok ? 4'hD : 4'h3);
        for (int i = 0; i < nnib; i++) drive(1'b1, i == er_pos, data_nib[i]);
        idle(gap);
    endtask

    task automatic check_counters(input string name);
        check({name, "_frames_ok"},  32'(frames_ok),  32'(exp_ok  % (1 << CW)));
        check({name, "_frames_bad"}, 32'(frames_bad), 32'(exp_bad % (1 << CW)));
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_outputs"},
              {13'd0, rx.rx_valid, rx.rx_sof, rx.rx_eof, rx.rx_err, rx.rx_len, rx.rx_byte}, 32'd0);
        check({name, "_counters"}, {frames_ok, frames_bad}, 32'd0);
        check({name, "_state"}, 32'(state), 32'(ST_IDLE));
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 40) begin
            @(posedge RX_CLK);
            #1;
            t++;
        end
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // reset
        @(posedge RX_CLK);
        #1;
        idle(3);
        check_reset_state("reset");
        rst = 1'b0;
        idle(4);

        // 1) basic two-byte frame
        data_nib = '{4'hB, 4'hA, 4'h2, 4'h1};
        send_frame(15, 1'b1, -1, 4);
        drain("t1");
        check_counters("t1");

        // 2) RX_ER on second nibble
        data_nib = '{4'hB, 4'hA, 4'h2, 4'h1};
        send_frame(15, 1'b1, 1, 4);
        drain("t2");
        check_counters("t2");

        // 3) short preamble rejected, minimum preamble accepted
        data_nib = '{4'h7, 4'h3};
        send_frame(1, 1'b1, -1, 2);
        send_frame(2, 1'b1, -1, 4);
        drain("t3");
        check_counters("t3");

        // 4) odd nibble count
        data_nib = '{4'h4, 4'hC, 4'h9};
        send_frame(7, 1'b1, -1, 4);
        drain("t4");

        // 5) overlength then a good frame
        data_nib = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
        send_frame(7, 1'b1, -1, 1);
        data_nib = '{4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        send_frame(7, 1'b1, -1, 4);
        drain("t5");
        check_counters("t5");

        // back-to-back frames with one idle cycle
        data_nib = '{4'h6, 4'h9};
        send_frame(3, 1'b1, -1, 1);
        data_nib = '{4'h0, 4'hF, 4'h5, 4'hD};
        send_frame(3, 1'b1, -1, 4);
        drain("b2b");
        check_counters("b2b");

        // 6) reset in the middle of a frame: nothing emitted, all cleared
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b0, 4'hD);
        drive(1'b1, 1'b0, 4'hB);
        drive(1'b1, 1'b0, 4'hA);
        rst = 1'b1;
        exp_ok  = 0;
        exp_bad = 0;
        idle(3);
        check_reset_state("midrst");
        rst = 1'b0;
        idle(4);
        data_nib = '{4'h3, 4'hC, 4'h8, 4'h8};
        send_frame(4, 1'b1, -1, 4);
        drain("t6");
        check_counters("t6");

        // randomized frames
        for (int f = 0; f < 60; f++) begin
            int pre_n;
            int nnib;
            int er_pos;
            bit sfd_ok;
            pre_n  = $urandom_range(0, 16);
            sfd_ok = ($urandom_range(0, 9) != 0);
            nnib   = $urandom_range(0, 13);
            er_pos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 13)) : -1;
            data_nib.delete();
            for (int i = 0; i < nnib; i++) data_nib.push_back(4'($urandom_range(0, 15)));
            send_frame(pre_n, sfd_ok, er_pos, $urandom_range(1, 3));
        end
        idle(4);
        drain("rand");
        check_counters("rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
